// File: rtl/stream_arbiter_mux_pkg.sv
// Shared definitions for the stream arbiter/mux family: select-width derivation and mode encodings.
package stream_arbiter_mux_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  // Select width for n channels; never narrower than one bit so a single channel still has a port.
  function automatic int unsigned sel_bits(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_arbiter_mux_rr_priority_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping at CHANNELS.
module rr_priority_picker
  import stream_arbiter_mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_BITS = sel_bits(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_BITS-1:0] last_grant,
  output logic [SEL_BITS-1:0] grant,
  output logic                grant_valid
);

  logic [SEL_BITS-1:0] idx;

  // Scan from the farthest offset down to the nearest so the nearest requester wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = int'(CHANNELS); i >= 1; i--) begin
      idx = SEL_BITS'((int'(last_grant) + i) % int'(CHANNELS));
      if (req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_arbiter_mux.sv
// N-channel valid/ready stream mux with addressed or round-robin selection and one output register.
module stream_arbiter_mux
  import stream_arbiter_mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8,
  localparam int unsigned SEL_BITS = sel_bits(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_BITS-1:0]       address,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_BITS-1:0]       out_channel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic                out_valid_q;
  logic [WIDTH-1:0]    out_data_q;
  logic [SEL_BITS-1:0] out_channel_q;
  logic [SEL_BITS-1:0] last_grant_q;

  logic [SEL_BITS-1:0] rr_grant;
  logic                rr_valid;
  logic [SEL_BITS-1:0] grant;
  logic                grant_valid;
  logic                addr_ok;
  logic                load_en;
  logic                xfer;
  logic [WIDTH-1:0]    sel_data;

  rr_priority_picker #(
    .CHANNELS (CHANNELS),
    .SEL_BITS (SEL_BITS)
  ) u_picker (
    .req         (in_valid),
    .last_grant  (last_grant_q),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  assign addr_ok = (32'(address) < CHANNELS);

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (mode == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end else if (addr_ok) begin
      grant       = address;
      grant_valid = in_valid[address];
    end
  end

  assign load_en = !out_valid_q || out_ready;
  // Reset gating keeps in_ready low while rst_n is held, even though load_en is high then.
  assign xfer    = load_en && grant_valid && rst_n;

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (grant == SEL_BITS'(k)) begin
        in_ready[k] = xfer;
        sel_data    = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      last_grant_q  <= SEL_BITS'(CHANNELS - 1);
    end else if (xfer) begin
      out_valid_q   <= 1'b1;
      out_data_q    <= sel_data;
      out_channel_q <= grant;
      last_grant_q  <= grant;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;

endmodule

// File: tb/tb_stream_arbiter_mux.sv
// Scoreboard bench for stream_arbiter_mux (4 channels x 8 bits) with directed stimulus.
module tb_stream_arbiter_mux;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  address;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_channel;
  logic        out_valid;
  logic        out_ready;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  stream_arbiter_mux #(
    .CHANNELS (4),
    .WIDTH    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .address     (address),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [7:0] d, input logic [1:0] c);
    sb_q.push_back({d, c});
  endtask

  // Monitor: a word is consumed at the next edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got data %0h ch %0d, required no output", out_data,
                 out_channel);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_out_data", 32'(out_data), 32'(mon_e.data));
        check("sb_out_channel", 32'(out_channel), 32'(mon_e.ch));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    address   = 2'd0;
    in_data   = 32'h0;
    in_valid  = 4'h0;
    out_ready = 1'b1;

    // Reset held while inputs toggle.
    for (int i = 0; i < 3; i++) begin
      in_valid  = 4'($urandom) | 4'h1;
      in_data   = $urandom;
      mode      = 1'($urandom);
      address   = 2'($urandom);
      out_ready = 1'($urandom);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'h00);
      check("rst_out_channel", 32'(out_channel), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'h0);
      tick();
    end

    // Release into round-robin with all channels requesting.
    mode      = 1'b1;
    in_valid  = 4'b1111;
    in_data   = 32'h13121110;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
      expect_word(8'h10 + 8'(k % 4), 2'(k % 4));
      tick();
    end

    // Skip idle channels: last grant is 0, so 1 then 3, 1, 3.
    in_valid = 4'b1010;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("skip_in_ready", 32'(in_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      expect_word((k % 2 == 0) ? 8'h11 : 8'h13, (k % 2 == 0) ? 2'd1 : 2'd3);
      tick();
    end

    // Addressed mode.
    mode              = 1'b0;
    address           = 2'd2;
    in_valid          = 4'b0100;
    in_data[16 +: 8]  = 8'hA5;
    #1;
    check("addr_in_ready", 32'(in_ready), 32'h4);
    expect_word(8'hA5, 2'd2);
    tick();
    check("addr_out_valid", 32'(out_valid), 32'd1);
    in_valid = 4'b1011;
    #1;
    check("addr_noreq_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("addr_drain_out_valid", 32'(out_valid), 32'd0);
    check("addr_keep_out_data", 32'(out_data), 32'hA5);
    check("addr_keep_out_channel", 32'(out_channel), 32'd2);

    // Backpressure: hold a word for five cycles, then consume and reload together.
    mode     = 1'b1;
    in_valid = 4'b0001;
    #1;
    check("bp_first_in_ready", 32'(in_ready), 32'h1);
    expect_word(8'h10, 2'd0);
    tick();
    out_ready       = 1'b0;
    in_data[0 +: 8] = 8'h55;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_hold_in_ready", 32'(in_ready), 32'h0);
      check("bp_hold_out_data", 32'(out_data), 32'h10);
      check("bp_hold_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'h1);
    expect_word(8'h55, 2'd0);
    tick();
    check("bp_nobubble_out_valid", 32'(out_valid), 32'd1);
    check("bp_nobubble_out_data", 32'(out_data), 32'h55);
    in_valid = 4'b0000;
    tick();
    check("bp_drain_out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while a word is held.
    in_data[0 +: 8] = 8'h77;
    in_valid        = 4'b0001;
    out_ready       = 1'b0;
    tick();
    check("hold_out_valid", 32'(out_valid), 32'd1);
    check("hold_out_data", 32'(out_data), 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_data", 32'(out_data), 32'h00);
    check("async_rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    rst_n     = 1'b1;
    in_valid  = 4'b0101;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h1);
    expect_word(8'h77, 2'd0);
    tick();
    in_valid = 4'b0000;
    tick();
    tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
